// File: rtl/einstein_kbd_matrix.sv
// PS/2 set-2 key events to Tatung Einstein 8x8 keyboard matrix plus SHIFT/CTRL/GRAPH lines.
// Row scans answer with one registered cycle of latency.
module einstein_kbd_matrix (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        clear,
  input  logic [7:0]  addr,
  output logic [7:0]  kb_cols,
  output logic [2:0]  modif,
  output logic        any_key
);

  // {extended, scancode} -> {valid, row[2:0], col[2:0]}
  function automatic logic [6:0] key_lookup(input logic [8:0] key);
    logic [6:0] e;
    case (key)
      9'h029: e = 7'b1_000_000; // SPACE
      9'h05A: e = 7'b1_000_001; // RETURN
      9'h066: e = 7'b1_000_010; // BACKSPACE
      9'h00D: e = 7'b1_000_011; // TAB
      9'h005: e = 7'b1_000_100; // F1
      9'h006: e = 7'b1_000_101; // F2
      9'h004: e = 7'b1_000_110; // F3
      9'h076: e = 7'b1_000_111; // ESC
      9'h16B: e = 7'b1_001_000; // LEFT
      9'h174: e = 7'b1_001_001; // RIGHT
      9'h175: e = 7'b1_001_010; // UP
      9'h172: e = 7'b1_001_011; // DOWN
      9'h00C: e = 7'b1_001_100; // F4
      9'h003: e = 7'b1_001_101; // F5
      9'h00B: e = 7'b1_001_110; // F6
      9'h083: e = 7'b1_001_111; // F7
      9'h015: e = 7'b1_010_000; // Q
      9'h01D: e = 7'b1_010_001; // W
      9'h024: e = 7'b1_010_010; // E
      9'h02D: e = 7'b1_010_011; // R
      9'h02C: e = 7'b1_010_100; // T
      9'h035: e = 7'b1_010_101; // Y
      9'h03C: e = 7'b1_010_110; // U
      9'h043: e = 7'b1_010_111; // I
      9'h04D: e = 7'b1_011_000; // P
      9'h01C: e = 7'b1_011_001; // A
      9'h01B: e = 7'b1_011_010; // S
      9'h023: e = 7'b1_011_011; // D
      9'h02B: e = 7'b1_011_100; // F
      9'h034: e = 7'b1_011_101; // G
      9'h033: e = 7'b1_011_110; // H
      9'h03B: e = 7'b1_011_111; // J
      9'h042: e = 7'b1_100_000; // K
      9'h04B: e = 7'b1_100_001; // L
      9'h04C: e = 7'b1_100_010; // ;
      9'h052: e = 7'b1_100_011; // '
      9'h01A: e = 7'b1_100_100; // Z
      9'h022: e = 7'b1_100_101; // X
      9'h021: e = 7'b1_100_110; // C
      9'h02A: e = 7'b1_100_111; // V
      9'h032: e = 7'b1_101_000; // B
      9'h031: e = 7'b1_101_001; // N
      9'h03A: e = 7'b1_101_010; // M
      9'h041: e = 7'b1_101_011; // ,
      9'h049: e = 7'b1_101_100; // .
      9'h04A: e = 7'b1_101_101; // /
      9'h044: e = 7'b1_101_110; // O
      9'h058: e = 7'b1_101_111; // CAPS LOCK
      9'h046: e = 7'b1_110_000; // 9
      9'h045: e = 7'b1_110_001; // 0
      9'h04E: e = 7'b1_110_010; // -
      9'h055: e = 7'b1_110_011; // =
      9'h054: e = 7'b1_110_100; // [
      9'h05B: e = 7'b1_110_101; // ]
      9'h05D: e = 7'b1_110_110; // backslash
      9'h171: e = 7'b1_110_111; // DELETE
      9'h016: e = 7'b1_111_000; // 1
      9'h01E: e = 7'b1_111_001; // 2
      9'h026: e = 7'b1_111_010; // 3
      9'h025: e = 7'b1_111_011; // 4
      9'h02E: e = 7'b1_111_100; // 5
      9'h036: e = 7'b1_111_101; // 6
      9'h03D: e = 7'b1_111_110; // 7
      9'h03E: e = 7'b1_111_111; // 8
      default: e = 7'b0_000_000;
    endcase
    return e;
  endfunction

  logic        strobe_r, armed_r;
  logic        ev_valid_r;
  logic [9:0]  ev_key_r;
  logic [63:0] matrix_r, matrix_nx_s;
  logic        shift_lt_r, shift_rt_r, ctrl_lt_r, ctrl_rt_r, graph_r;
  logic        shift_lt_nx_s, shift_rt_nx_s, ctrl_lt_nx_s, ctrl_rt_nx_s, graph_nx_s;
  logic [6:0]  lk_s;
  logic [7:0]  cols_or_s;
  logic        any_s;

  // Toggle tracking and capture of one pending event for next-cycle decode
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      strobe_r   <= 1'b0;
      armed_r    <= 1'b0;
      ev_valid_r <= 1'b0;
      ev_key_r   <= 10'd0;
    end else begin
      strobe_r   <= ps2_key[10];
      armed_r    <= 1'b1;
      ev_valid_r <= armed_r && (ps2_key[10] != strobe_r) && !clear;
      ev_key_r   <= ps2_key[9:0];
    end
  end

  // Next key state: clear wins over any pending event; modifiers bypass the map
  always_comb begin
    matrix_nx_s   = matrix_r;
    shift_lt_nx_s = shift_lt_r;
    shift_rt_nx_s = shift_rt_r;
    ctrl_lt_nx_s  = ctrl_lt_r;
    ctrl_rt_nx_s  = ctrl_rt_r;
    graph_nx_s    = graph_r;
    lk_s          = key_lookup(ev_key_r[8:0]);
    if (clear) begin
      matrix_nx_s   = 64'd0;
      shift_lt_nx_s = 1'b0;
      shift_rt_nx_s = 1'b0;
      ctrl_lt_nx_s  = 1'b0;
      ctrl_rt_nx_s  = 1'b0;
      graph_nx_s    = 1'b0;
    end else if (ev_valid_r) begin
      case (ev_key_r[7:0])
        8'h12: shift_lt_nx_s = ev_key_r[9];
        8'h59: shift_rt_nx_s = ev_key_r[9];
        8'h14: begin
          if (ev_key_r[8]) begin
            ctrl_rt_nx_s = ev_key_r[9];
          end else begin
            ctrl_lt_nx_s = ev_key_r[9];
          end
        end
        8'h11: graph_nx_s = ev_key_r[9];
        default: begin
          if (lk_s[6]) begin
            matrix_nx_s[lk_s[5:0]] = ev_key_r[9];
          end else begin
            matrix_nx_s = matrix_r;
          end
        end
      endcase
    end else begin
      matrix_nx_s = matrix_r;
    end
  end

  // Key state registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      matrix_r   <= 64'd0;
      shift_lt_r <= 1'b0;
      shift_rt_r <= 1'b0;
      ctrl_lt_r  <= 1'b0;
      ctrl_rt_r  <= 1'b0;
      graph_r    <= 1'b0;
    end else begin
      matrix_r   <= matrix_nx_s;
      shift_lt_r <= shift_lt_nx_s;
      shift_rt_r <= shift_rt_nx_s;
      ctrl_lt_r  <= ctrl_lt_nx_s;
      ctrl_rt_r  <= ctrl_rt_nx_s;
      graph_r    <= graph_nx_s;
    end
  end

  // Column scan: OR pressed keys of every selected (low) row, per column
  always_comb begin
    cols_or_s = 8'd0;
    for (int n = 0; n < 8; n++) begin
      if (!addr[n]) begin
        cols_or_s = cols_or_s | matrix_r[n*8 +: 8];
      end else begin
        cols_or_s = cols_or_s;
      end
    end
    any_s = (|matrix_r) | shift_lt_r | shift_rt_r | ctrl_lt_r | ctrl_rt_r | graph_r;
  end

  // Registered outputs to the core
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      kb_cols <= 8'hFF;
      modif   <= 3'b000;
      any_key <= 1'b0;
    end else begin
      kb_cols <= ~cols_or_s;
      modif   <= {ctrl_lt_r | ctrl_rt_r, graph_r, shift_lt_r | shift_rt_r};
      any_key <= any_s;
    end
  end

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Self-checking bench for einstein_kbd_matrix: directed steps then random events
// against a behavioural model of held keys and modifiers.
`timescale 1ns/1ps
module tb_einstein_kbd_matrix;
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic        clear   = 1'b0;
  logic [7:0]  addr    = 8'h00;
  logic [7:0]  kb_cols;
  logic [2:0]  modif;
  logic        any_key;

  int n_cmp = 0;
  int n_err = 0;

  logic held [8][8];
  logic m_shl, m_shr, m_ctl, m_ctr, m_gr;
  logic tog = 1'b1;

  einstein_kbd_matrix dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .clear   (clear),
    .addr    (addr),
    .kb_cols (kb_cols),
    .modif   (modif),
    .any_key (any_key)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Known positions from the key-map sheet: {valid, row, col}
  function automatic logic [6:0] ref_map(input logic [8:0] k);
    case (k)
      9'h01C:  return {1'b1, 3'd3, 3'd1};
      9'h029:  return {1'b1, 3'd0, 3'd0};
      9'h05A:  return {1'b1, 3'd0, 3'd1};
      9'h016:  return {1'b1, 3'd7, 3'd0};
      9'h175:  return {1'b1, 3'd1, 3'd2};
      9'h172:  return {1'b1, 3'd1, 3'd3};
      9'h076:  return {1'b1, 3'd0, 3'd7};
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_cols();
    logic [7:0] r;
    r = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int n = 0; n < 8; n++)
        if (addr[n] == 1'b0 && held[n][c]) r[c] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] exp_modif();
    return {5'd0, m_ctl | m_ctr, m_gr, m_shl | m_shr};
  endfunction

  function automatic logic [7:0] exp_any();
    logic a;
    a = m_shl | m_shr | m_ctl | m_ctr | m_gr;
    for (int n = 0; n < 8; n++)
      for (int c = 0; c < 8; c++)
        a = a | held[n][c];
    return {7'd0, a};
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 8; n++)
      for (int c = 0; c < 8; c++)
        held[n][c] = 1'b0;
    m_shl = 1'b0; m_shr = 1'b0; m_ctl = 1'b0; m_ctr = 1'b0; m_gr = 1'b0;
  endtask

  task automatic model_apply(input logic [8:0] k, input logic p);
    logic [6:0] e;
    e = ref_map(k);
    if (k[7:0] == 8'h12) m_shl = p;
    else if (k[7:0] == 8'h59) m_shr = p;
    else if (k[7:0] == 8'h14) begin
      if (k[8]) m_ctr = p; else m_ctl = p;
    end
    else if (k[7:0] == 8'h11) m_gr = p;
    else if (e[6]) held[e[5:3]][e[2:0]] = p;
  endtask

  task automatic post(input logic [8:0] k, input logic p);
    tog = ~tog;
    ps2_key = {tog, p, k};
  endtask

  task automatic send(input logic [8:0] k, input logic p);
    post(k, p);
    model_apply(k, p);
    tick(3);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_cols"}, kb_cols, exp_cols());
    chk({tag, "_modif"}, {5'd0, modif}, exp_modif());
    chk({tag, "_any"}, {7'd0, any_key}, exp_any());
  endtask

  logic [8:0] keys [16] = '{9'h01C, 9'h029, 9'h05A, 9'h016, 9'h175, 9'h172, 9'h076, 9'h00E,
                            9'h075, 9'h072, 9'h11C, 9'h012, 9'h059, 9'h014, 9'h114, 9'h011};

  initial begin
    logic [8:0] k;
    logic       p;
    model_clear();

    tick(3);
    chk("rst_cols", kb_cols, 8'hFF);
    chk("rst_modif", {5'd0, modif}, 8'h00);
    chk("rst_any", {7'd0, any_key}, 8'h00);
    reset = 1'b0;
    tick(4);
    chk_all("arm");

    // 'A' with exact two-edge latency
    addr = 8'hF7;
    tick(2);
    post(9'h01C, 1'b1);
    model_apply(9'h01C, 1'b1);
    tick(1);
    chk("a_edge_n", kb_cols, 8'hFF);
    tick(1);
    chk("a_edge_n1", kb_cols, 8'hFF);
    tick(1);
    chk("a_edge_n2", kb_cols, 8'hFD);
    send(9'h01C, 1'b0); chk_all("a_rel");
    addr = 8'hFE;
    send(9'h01C, 1'b1); chk_all("a_row0");
    send(9'h01C, 1'b0);

    addr = 8'hF6;
    send(9'h029, 1'b1);
    send(9'h01C, 1'b1); chk_all("sp_a");
    chk("sp_a_lit", kb_cols, 8'hFC);
    addr = 8'hFF; tick(2); chk_all("addr_ff");
    addr = 8'hF6;
    send(9'h029, 1'b0); chk_all("sp_rel");
    send(9'h01C, 1'b1); chk_all("a_repeat");
    send(9'h05A, 1'b0); chk_all("rel_not_held");

    send(9'h012, 1'b1); chk_all("lsh");
    send(9'h059, 1'b1); chk_all("lrsh");
    send(9'h012, 1'b0); chk_all("rsh");
    chk("rsh_lit", {5'd0, modif}, 8'h01);
    send(9'h059, 1'b0); chk_all("nosh");
    send(9'h114, 1'b1); chk_all("rctrl");
    chk("rctrl_lit", {5'd0, modif}, 8'h04);
    send(9'h114, 1'b0);

    addr = 8'hFD;
    send(9'h175, 1'b1); chk_all("up");
    send(9'h075, 1'b1); chk_all("kp8");
    send(9'h175, 1'b0);
    send(9'h01C, 1'b0);
    send(9'h00E, 1'b1); chk_all("unmapped");

    // clear coincident with ESC toggle
    addr = 8'h00;
    send(9'h016, 1'b1);
    send(9'h05A, 1'b1);
    send(9'h029, 1'b1);
    send(9'h014, 1'b1); chk_all("pre_clr");
    post(9'h076, 1'b1);
    clear = 1'b1;
    model_clear();
    tick(1);
    clear = 1'b0;
    tick(3); chk_all("clr");
    addr = 8'hFE; tick(2); chk_all("clr_esc");
    send(9'h076, 1'b1); chk_all("after_clr");
    chk("after_clr_lit", kb_cols, 8'h7F);

    for (int i = 0; i < 200; i++) begin
      k = keys[$urandom_range(0, 15)];
      p = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        post(k, p);
        clear = 1'b1;
        model_clear();
        tick(1);
        clear = 1'b0;
        tick(3);
      end else begin
        send(k, p);
      end
      chk_all("rnd");
    end

    // reset while an event is in flight
    addr = 8'h00;
    send(9'h01C, 1'b1);
    post(9'h029, 1'b1);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    model_clear();
    tick(1);
    chk_all("mid_rst");
    reset = 1'b0;
    tick(4); chk_all("rearm");
    send(9'h029, 1'b1); chk_all("post_rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/einstein_kbd_matrix.md
Name: einstein_kbd_matrix

Overview:
- Converts MiSTer `ps2_key` events into the Tatung Einstein 8x8 keyboard matrix.
- Also produces the three modifier lines (SHIFT, CTRL, GRAPH), which are not part of the matrix.
- Sits between `hps_io` (upstream) and the Einstein core. The core drives `addr` from the PSG port A row select and reads `kb_cols` through PSG port B.
- Holds the pressed/released state of every key and answers row scans with one-cycle registered latency.

Parameters:
- None. The key map is a fixed internal lookup: 9-bit {extended, scancode} -> {valid, row[2:0], col[2:0]}.

Ports:
- `clk_sys`  in  1  system clock (32 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `ps2_key`  in  11  [10] event toggle, [9] pressed=1/released=0, [8] E0-extended, [7:0] set-2 scancode
- `clear`  in  1  synchronous release-all (asserted by top level on OSD open)
- `addr`  in  8  row select, active-low; bit n low selects row n
- `kb_cols`  out  8  column data, active-low; bit c low = key at (selected row, c) pressed
- `modif`  out  3  {ctrl, graph, shift}, active-high
- `any_key`  out  1  high while any matrix key or modifier is held

Behaviour:
- Reset values, async, while `reset` high:
  - matrix all released
  - `kb_cols` = 8'hFF
  - `modif` = 3'b000
  - `any_key` = 0
  - `strobe_q` = 0
  - `armed` = 0
- Arming:
  - First `clk_sys` edge after reset deassert: `strobe_q` <= `ps2_key[10]`, `armed` <= 1, no event processed.
  - This prevents a spurious event when `ps2_key[10]` is 1 at reset.
- Event detect:
  - Event when `armed` and `ps2_key[10]` != `strobe_q`; `strobe_q` updates every cycle after arming.
  - Edge N = toggle first seen; state update lands at edge N+1 (one-cycle registered decode).
- Event decode, checked in this order:
  1. code 8'h12 (L-shift) / 8'h59 (R-shift): `shift_l` / `shift_r` <= pressed; `shift` = `shift_l` | `shift_r`.
  2. 8'h14: `ctrl_l` (ext=0) or `ctrl_r` (ext=1) <= pressed; `ctrl` = OR of both.
  3. 8'h11: `graph` <= pressed (either ALT).
  4. Otherwise look up {ext, code}. If valid, `matrix[row][col]` <= pressed. If invalid, ignore; no state change.
- Required map entries (full table in the key-map sheet):
  - 1C 'A' -> r3 c1
  - 29 SPACE -> r0 c0
  - 5A RETURN -> r0 c1
  - 16 '1' -> r7 c0
  - E0 75 UP -> r1 c2
  - E0 72 DOWN -> r1 c3
  - 76 ESC -> r0 c7
- Repeated press of a held key: no-op. Release of a key not held: no-op.
- `clear` high: all matrix bits and modifiers released at the next edge. `clear` has priority over a simultaneous event; that event is discarded, but `strobe_q` still tracks.
- Column read:
  - `kb_cols` registered: `kb_cols[c]` = NOT( OR over n where `addr[n]`==0 of `matrix[n][c]` ).
  - Multiple rows selected -> wired-AND of active-low columns.
  - `addr` = FF -> FF.
  - Latency: `addr` change at edge M is visible on `kb_cols` after edge M+1. A matrix update at edge N+1 is visible after edge N+2.
- `any_key`: registered OR of all 64 matrix bits and the 3 modifiers; same timing as `kb_cols`.
- Async reset mid-event: event lost, state cleared, re-arm as above.

Test Plan:
- Reset with `ps2_key`=11'h400 held, release reset, hold 4 cycles -> `kb_cols`=FF, `any_key`=0; no event processed.
- Press 'A' (toggle, [9]=1, code 1C), `addr`=F7 -> `kb_cols`=FD exactly 2 edges after toggle. Release (code 1C, [9]=0) -> FF. `addr`=FE throughout -> FF.
- Press SPACE and 'A', `addr`=F6 -> FC. `addr`=FF -> FF. Release SPACE only -> FD.
- Press L-shift, press R-shift, release L-shift -> `modif`=001 throughout. Release R-shift -> 000. E0 14 press -> `modif`=100.
- Press E0 75 -> r1 c2 set. Plain 75 press -> no matrix change. Unmapped 0x0E -> no change; `any_key` stays 0.
- Hold three keys plus CTRL, pulse `clear` in the same cycle as a new toggle for ESC -> all released, `modif`=000, ESC not set. The next toggle is processed normally.
